// File: rtl/mm_if.sv
// Stream interface for mm_core: element input, C output and status.
// master = producer/consumer side (board top or bench), slave = the core.
interface mm_if #(
    parameter int DW = 8,
    parameter int OW = 16
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/mm_core.sv
// mm_core: N x N unsigned matrix multiply C = A*B.
// Loads A then B row-major, runs one MAC per cycle (N^3 cycles), then
// streams C row-major. Define MM_SAT_EN to saturate C elements to OW bits
// instead of truncating them (latency is identical in both builds).
module mm_core #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int OW = 16
) (
    input logic clk,
    input logic rst,
    mm_if.slave bus
);
    localparam int AW = 2*DW + $clog2(N);
    localparam int EW = (AW > OW) ? AW : OW;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N*N);
    localparam int NN = N*N;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] oidx_q, oidx_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          done_q, done_d;

    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [OW-1:0] c_mem [NN];

    logic          a_we, b_we, c_we;
    logic          in_xfer, out_xfer;
    logic [IW-1:0] a_idx, b_idx, c_idx;
    logic [2*DW-1:0] prod;
    logic [AW-1:0] sum;

    // Sum of N products of DW-bit operands always fits AW bits, so only
    // the final narrowing to OW bits can lose information.
    function automatic logic [OW-1:0] fmt(input logic [AW-1:0] x);
        logic [EW-1:0] xe;
        xe = EW'(x);
`ifdef MM_SAT_EN
        if (xe > EW'({OW{1'b1}}))
            xe = EW'({OW{1'b1}});
`endif
        return xe[OW-1:0];
    endfunction

    assign a_idx = IW'(int'(i_q)*N + int'(k_q));
    assign b_idx = IW'(int'(k_q)*N + int'(j_q));
    assign c_idx = IW'(int'(i_q)*N + int'(j_q));
    assign prod  = (2*DW)'(a_mem[a_idx]) * (2*DW)'(b_mem[b_idx]);
    assign sum   = acc_q + AW'(prod);

    // Outputs are forced idle while reset is asserted.
    assign bus.in_ready  = rst && (state_q == LOAD_A || state_q == LOAD_B);
    assign bus.out_valid = rst && (state_q == DRAIN);
    assign bus.out_data  = bus.out_valid ? c_mem[oidx_q] : '0;
    assign bus.busy      = rst && (state_q == COMPUTE || state_q == DRAIN);
    assign bus.done      = rst && done_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    // Next-state, index and accumulator logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oidx_d  = oidx_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        c_we    = 1'b0;
        case (state_q)
            LOAD_A: if (in_xfer) begin
                a_we = 1'b1;
                if (idx_q == IW'(NN-1)) begin
                    idx_d   = '0;
                    state_d = LOAD_B;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            LOAD_B: if (in_xfer) begin
                b_we = 1'b1;
                if (idx_q == IW'(NN-1)) begin
                    idx_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            COMPUTE: begin
                if (k_q == CW'(N-1)) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == CW'(N-1)) begin
                        j_d = '0;
                        if (i_q == CW'(N-1)) begin
                            i_d     = '0;
                            oidx_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            DRAIN: if (out_xfer) begin
                if (oidx_q == IW'(NN-1)) begin
                    oidx_d  = '0;
                    done_d  = 1'b1;
                    state_d = LOAD_A;
                end else begin
                    oidx_d = oidx_q + 1'b1;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            oidx_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oidx_q  <= oidx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    // Matrix storage: not cleared by reset, writes suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst && a_we) a_mem[idx_q] <= bus.in_data;
        if (rst && b_we) b_mem[idx_q] <= bus.in_data;
        if (rst && c_we) c_mem[c_idx] <= fmt(sum);
    end
endmodule

// File: tb/tb_mm_core.sv
// Bench for mm_core: table of matrix pairs run through a reference matmul
// model into a scoreboard, plus reset-mid-compute and N=2 sequences.
module tb_mm_core;
    logic clk = 1'b0;
    logic rst = 1'b0;

    mm_if #(.DW(8), .OW(16)) bus ();
    mm_if #(.DW(4), .OW(8))  bus2 ();

    mm_core #(.N(4), .DW(8), .OW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mm_core #(.N(2), .DW(4), .OW(8))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        bit               stall;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] fmt16(input longint s);
`ifdef MM_SAT_EN
        if (s > 65535) return 16'hFFFF;
`endif
        return s[15:0];
    endfunction

    function automatic void push_expected(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'(a[i*4+k]) * longint'(b[k*4+j]);
                sb.push_back(fmt16(s));
            end
    endfunction

    task automatic send(input logic [7:0] d);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("load_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
    endtask

    // Leaves in_valid high with junk data so COMPUTE must ignore it.
    task automatic load(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
        for (int e = 0; e < 16; e++) send(a[e]);
        for (int e = 0; e < 16; e++) send(b[e]);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
    endtask

    task automatic compute_phase();
        int cyc = 0;
        bit ir_seen = 0;
        bit busy_lo = 0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.in_ready) ir_seen = 1;
            if (!bus.busy) busy_lo = 1;
            @(posedge clk); #1; cyc++;
        end
        bus.in_valid = 1'b0;
        check("compute_cycles", cyc, 64);
        check("in_ready_low_in_compute", ir_seen, 0);
        check("busy_high_in_compute", busy_lo, 0);
    endtask

    task automatic drain(input bit stall);
        int          got  = 0;
        int          cyc  = 0;
        bit          pend = 0;
        logic [15:0] hold = '0;
        logic [15:0] exp;
        while (got < 16 && cyc < 500) begin
            if (pend) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, hold);
            end
            check("done_low_in_drain", bus.done, 0);
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
                check("c_elem", bus.out_data, exp);
                got++;
                pend = 0;
            end else begin
                pend = bus.out_valid;
                hold = bus.out_data;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.out_ready = 1'b0;
        check("drain_count", got, 16);
        check("sb_empty", sb.size(), 0);
        check("end_out_valid", bus.out_valid, 0);
        check("end_done", bus.done, 1);
        check("end_in_ready", bus.in_ready, 1);
        check("end_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0][7:0] ident, twoi, ones;
        logic [3:0]       n2_in[8];
        logic [7:0]       n2_exp[4];
        int               cyc;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

        for (int e = 0; e < 16; e++) begin
            ident[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
            twoi[e]  = (e / 4 == e % 4) ? 8'd2 : 8'd0;
            ones[e]  = 8'd1;
        end
        vecs[0].name = "identity";
        vecs[0].a = ident; vecs[0].stall = 0;
        for (int e = 0; e < 16; e++) vecs[0].b[e] = 8'(e + 1);
        vecs[1].name = "all_ff";
        vecs[1].stall = 0;
        for (int e = 0; e < 16; e++) begin vecs[1].a[e] = 8'hFF; vecs[1].b[e] = 8'hFF; end
        vecs[2].name = "ones_stall";
        vecs[2].a = ones; vecs[2].b = ones; vecs[2].stall = 1;
        vecs[3].name = "random_stall";
        vecs[3].stall = 1;
        for (int e = 0; e < 16; e++) begin
            vecs[3].a[e] = 8'($urandom_range(0, 255));
            vecs[3].b[e] = 8'($urandom_range(0, 255));
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Table-driven vectors
        for (int v = 0; v < 4; v++) begin
            push_expected(vecs[v].a, vecs[v].b);
            load(vecs[v].a, vecs[v].b);
            compute_phase();
            drain(vecs[v].stall);
        end

        // Reset in the middle of COMPUTE, then reload A=I, B=2I
        load(ones, ones);
        repeat (30) @(posedge clk);
        #1;
        check("mid_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_in_ready_after", bus.in_ready, 1);
        push_expected(ident, twoi);
        load(ident, twoi);
        compute_phase();
        drain(0);

        // N=2, DW=4, OW=8 instance
        n2_in  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        n2_exp = '{8'd19, 8'd22, 8'd43, 8'd50};
        for (int e = 0; e < 8; e++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = n2_in[e];
            check("n2_in_ready", bus2.in_ready, 1);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        cyc = 0;
        while (!bus2.out_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("n2_compute_cycles", cyc, 8);
        bus2.out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            check("n2_out_valid", bus2.out_valid, 1);
            check("n2_out_data", bus2.out_data, n2_exp[e]);
            @(posedge clk); #1;
        end
        bus2.out_ready = 1'b0;
        check("n2_done", bus2.done, 1);
        check("n2_out_valid_end", bus2.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
